// File: rtl/register_file.sv
// ============================================================================
// register_file: 32 x 32-bit MIPS general register file, three combinational
// read ports, one write port with optional write-first forwarding.
// Revision: 1.0
// ============================================================================
`default_nettype none

module register_file #(
  parameter int          DATA_W  = 32,
  parameter int          ADDR_W  = 5,
  parameter logic [31:0] SP_INIT = 32'h0000_3FFC,
  parameter logic [31:0] GP_INIT = 32'h0000_1800,
  parameter bit          BYPASS  = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  input  logic [ADDR_W-1:0] rd_addr3,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic [DATA_W-1:0] rd_data3,
  output logic [15:0]       write_count
);

  localparam int          C_DEPTH   = 2**ADDR_W;
  localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

  logic [DATA_W-1:0] r_regs [C_DEPTH];
  logic [15:0]       r_write_count;
  logic              w_commit;
  logic              w_fwd;

  assign w_commit = wr_en && (wr_addr != '0);
  // Forwarding is suppressed during reset because the write is dropped.
  assign w_fwd    = (BYPASS != 1'b0) && w_commit && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < C_DEPTH; i++) begin
        if (i == 28)
          r_regs[i] <= GP_INIT[DATA_W-1:0];
        else if (i == 29)
          r_regs[i] <= SP_INIT[DATA_W-1:0];
        else
          r_regs[i] <= '0;
      end
      r_write_count <= '0;
    end else if (w_commit) begin
      r_regs[wr_addr] <= wr_data;
      if (r_write_count != C_CNT_MAX)
        r_write_count <= r_write_count + 16'd1;
    end
  end

  function automatic logic [DATA_W-1:0] f_read(input logic [ADDR_W-1:0] addr);
    if (addr == '0)
      return '0;
    else if (w_fwd && (addr == wr_addr))
      return wr_data;
    else
      return r_regs[addr];
  endfunction

  assign rd_data1    = f_read(rd_addr1);
  assign rd_data2    = f_read(rd_addr2);
  assign rd_data3    = f_read(rd_addr3);
  assign write_count = r_write_count;

endmodule

`default_nettype wire

// File: tb/tb_register_file.sv
// ============================================================================
// tb_register_file: checks register_file (BYPASS=1 and BYPASS=0) against an
// array model every cycle, plus directed literal expectations.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_register_file;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  rd_addr1 = '0, rd_addr2 = '0, rd_addr3 = '0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;

  logic [31:0] b_rd1, b_rd2, b_rd3;
  logic [15:0] b_cnt;
  logic [31:0] n_rd1, n_rd2, n_rd3;
  logic [15:0] n_cnt;

  int checks = 0;
  int passes = 0;

  register_file #(.BYPASS(1'b1)) dut (
    .clk(clk), .reset(reset),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_addr3(rd_addr3),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_data1(b_rd1), .rd_data2(b_rd2), .rd_data3(b_rd3),
    .write_count(b_cnt)
  );

  register_file #(.BYPASS(1'b0)) dut_nobyp (
    .clk(clk), .reset(reset),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_addr3(rd_addr3),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_data1(n_rd1), .rd_data2(n_rd2), .rd_data3(n_rd3),
    .write_count(n_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: plain array plus saturating counter.
  logic [31:0] m_regs [32];
  int          m_count = 0;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] <= '0;
      m_regs[28] <= 32'h0000_1800;
      m_regs[29] <= 32'h0000_3FFC;
      m_count    <= 0;
      m_valid    <= 1'b1;
    end else if (wr_en && wr_addr != 5'd0) begin
      m_regs[wr_addr] <= wr_data;
      if (m_count < 65535) m_count <= m_count + 1;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'd0;
    if (byp && wr_en && wr_addr != 5'd0 && !reset && a == wr_addr) return wr_data;
    return m_regs[a];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      check("byp_rd1", b_rd1, exp_rd(rd_addr1, 1'b1));
      check("byp_rd2", b_rd2, exp_rd(rd_addr2, 1'b1));
      check("byp_rd3", b_rd3, exp_rd(rd_addr3, 1'b1));
      check("byp_cnt", {16'd0, b_cnt}, 32'(m_count));
      check("nob_rd1", n_rd1, exp_rd(rd_addr1, 1'b0));
      check("nob_rd2", n_rd2, exp_rd(rd_addr2, 1'b0));
      check("nob_rd3", n_rd3, exp_rd(rd_addr3, 1'b0));
      check("nob_cnt", {16'd0, n_cnt}, 32'(m_count));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic peek();
    @(negedge clk);
    #1;
  endtask

  initial begin
    // Reset cycle
    tick();
    reset = 1'b0;
    rd_addr1 = 5'd0; rd_addr2 = 5'd28; rd_addr3 = 5'd29;
    peek();
    check("rst_r0",  b_rd1, 32'd0);
    check("rst_r28", b_rd2, 32'h0000_1800);
    check("rst_r29", b_rd3, 32'h0000_3FFC);
    check("rst_cnt", {16'd0, b_cnt}, 32'd0);
    tick();
    rd_addr1 = 5'd5;
    peek();
    check("rst_r5", b_rd1, 32'd0);

    // Write reg 8, read on two ports next cycle
    tick();
    wr_en = 1'b1; wr_addr = 5'd8; wr_data = 32'hDEAD_BEEF;
    tick();
    wr_en = 1'b0; rd_addr1 = 5'd8; rd_addr2 = 5'd8;
    peek();
    check("r8_p1", b_rd1, 32'hDEAD_BEEF);
    check("r8_p2", b_rd2, 32'hDEAD_BEEF);
    check("r8_cnt", {16'd0, b_cnt}, 32'd1);

    // Write to register 0 is ignored
    tick();
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF; rd_addr1 = 5'd0;
    peek();
    check("r0_same", b_rd1, 32'd0);
    tick();
    wr_en = 1'b0;
    peek();
    check("r0_next", b_rd1, 32'd0);
    check("r0_cnt", {16'd0, b_cnt}, 32'd1);

    // Same-cycle forwarding vs. no forwarding
    tick();
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h1234_5678; rd_addr1 = 5'd9;
    peek();
    check("byp_fwd", b_rd1, 32'h1234_5678);
    check("nob_old", n_rd1, 32'd0);
    tick();
    wr_en = 1'b0;
    peek();
    check("nob_new", n_rd1, 32'h1234_5678);
    check("fwd_cnt", {16'd0, n_cnt}, 32'd2);

    // Reset wins over a concurrent write
    tick();
    wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'd7; rd_addr1 = 5'd10;
    tick();
    wr_en = 1'b0;
    peek();
    check("r10_7", b_rd1, 32'd7);
    tick();
    reset = 1'b1; wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'd99;
    peek();
    check("rst_rd_old", b_rd1, 32'd7);
    tick();
    reset = 1'b0; wr_en = 1'b0; rd_addr2 = 5'd28; rd_addr3 = 5'd8;
    peek();
    check("rst_r10", b_rd1, 32'd0);
    check("rst_r8", b_rd3, 32'd0);
    check("rst_gp", b_rd2, 32'h0000_1800);
    check("rst_cnt2", {16'd0, b_cnt}, 32'd0);

    // Counter saturation
    tick();
    wr_addr = 5'd3; rd_addr3 = 5'd3;
    for (int i = 0; i < 65540; i++) begin
      wr_en = 1'b1; wr_data = 32'(i + 1);
      tick();
      if (i == 65533) check("cnt_fffe", {16'd0, b_cnt}, 32'h0000_FFFE);
    end
    wr_en = 1'b0;
    peek();
    check("sat_cnt", {16'd0, b_cnt}, 32'h0000_FFFF);
    check("sat_r3", b_rd3, 32'd65540);
    check("sat_cnt_nb", {16'd0, n_cnt}, 32'h0000_FFFF);

    tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
